// File: rtl/seq_adder_pkg.sv
// rtl/seq_adder_pkg.sv - shared state type and index-width helper for seq_chunk_adder
package seq_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int idx_width(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk.sv
// rtl/seq_chunk_adder_chunk.sv - combinational CHUNK-bit ripple-carry adder slice
module chunk_adder #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] sum,
   output logic             co
);

   logic [CHUNK:0] w_c;

   assign w_c[0] = ci;

   for (genvar g = 0; g < CHUNK; g++) begin : g_fa
      assign sum[g]    = x[g] ^ y[g] ^ w_c[g];
      assign w_c[g+1]  = (x[g] & y[g]) | (w_c[g] & (x[g] ^ y[g]));
   end

   assign co = w_c[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle chunked adder with start/done; SEQ_ADDER_SUB_EN adds subtract
module seq_chunk_adder
   import seq_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SEQ_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = idx_width(NCHUNK);

   if (WIDTH < 2) begin : g_chk_width
      $fatal(1, "seq_chunk_adder: WIDTH must be at least 2");
   end
   if ((WIDTH % CHUNK) != 0) begin : g_chk_chunk
      $fatal(1, "seq_chunk_adder: WIDTH must be a multiple of CHUNK");
   end

   state_t            r_state;
   state_t            w_next;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [WIDTH-1:0]  r_s;
   logic              r_carry;
   logic              r_cout;
   logic              r_ovf;
   logic [IDXW-1:0]   r_idx;

   logic              w_accept;
   logic              w_last;
   logic [CHUNK-1:0]  w_a_ch [NCHUNK];
   logic [CHUNK-1:0]  w_b_ch [NCHUNK];
   logic [CHUNK-1:0]  w_sum;
   logic              w_co;
   logic [WIDTH-1:0]  w_s_next;

   // Operands are sliced into chunk arrays so the active chunk is a plain index by r_idx.
   for (genvar g = 0; g < NCHUNK; g++) begin : g_slice
      assign w_a_ch[g] = r_a[g*CHUNK +: CHUNK];
      assign w_b_ch[g] = r_b[g*CHUNK +: CHUNK];
      assign w_s_next[g*CHUNK +: CHUNK] = (r_idx == IDXW'(g)) ? w_sum : r_s[g*CHUNK +: CHUNK];
   end

   chunk_adder #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .x   (w_a_ch[r_idx]),
      .y   (w_b_ch[r_idx]),
      .ci  (r_carry),
      .sum (w_sum),
      .co  (w_co)
   );

   assign w_last   = (r_idx == IDXW'(NCHUNK - 1));
   assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = RUN;
         RUN:     if (w_last) w_next = DONE;
         DONE:    w_next = start ? RUN : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_idx   <= '0;
      end else if (w_accept) begin
         r_a   <= a;
         r_idx <= '0;
`ifdef SEQ_ADDER_SUB_EN
         r_b     <= sub ? ~b : b;
         r_carry <= sub ? 1'b1 : cin;
`else
         r_b     <= b;
         r_carry <= cin;
`endif
      end else if (r_state == RUN) begin
         r_s     <= w_s_next;
         r_carry <= w_co;
         r_idx   <= r_idx + 1'b1;
         if (w_last) begin
            r_cout <= w_co;
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[CHUNK-1] != r_a[WIDTH-1]);
         end
      end
   end

   assign busy = (r_state == RUN);
   assign done = (r_state == DONE);
   assign s    = r_s;
   assign cout = r_cout;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - randomized self-checking bench for seq_chunk_adder
module tb_seq_chunk_adder;

   localparam int WIDTH  = 8;
   localparam int CHUNK  = 2;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   seq_chunk_adder #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SEQ_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .s     (s),
      .cout  (cout),
      .ovf   (ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands as issued.
   task automatic model(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input logic isub, output logic [7:0] es, output logic ec,
                        output logic eo);
      int sa;
      int sb;
      int r;
      sa = $signed(ia);
      sb = $signed(ib);
      if (isub) begin
         es = ia - ib;
         ec = (ia >= ib);
         r  = sa - sb;
      end else begin
         {ec, es} = {1'b0, ia} + {1'b0, ib} + {8'b0, ic};
         r  = sa + sb + int'(ic);
      end
      eo = (r > 127) || (r < -128);
   endtask

   task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input logic isub, input string tag);
      logic [7:0] es;
      logic       ec;
      logic       eo;
      int         lat;
      model(ia, ib, ic, isub, es, ec, eo);
      @(negedge clk);
      a = ia; b = ib; cin = ic; sub = isub; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, ":busy_t0"}, 32'(busy), 32'd1);
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         check({tag, ":busy"}, 32'(busy), 32'(!done));
      end
      check({tag, ":latency"}, 32'(lat), 32'(NCHUNK));
      check({tag, ":s"}, 32'(s), 32'(es));
      check({tag, ":cout"}, 32'(cout), 32'(ec));
      check({tag, ":ovf"}, 32'(ovf), 32'(eo));
      @(posedge clk);
      #1;
      check({tag, ":done_1cyc"}, 32'(done), 32'd0);
      check({tag, ":s_hold"}, 32'(s), 32'(es));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         pulses;
      int         last;
      logic [7:0] es;
      logic       ec;
      logic       eo;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rs;

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst:busy", 32'(busy), 32'd0);
      check("rst:done", 32'(done), 32'd0);
      check("rst:s", 32'(s), 32'd0);
      check("rst:cout", 32'(cout), 32'd0);
      check("rst:ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(8'h3C, 8'h05, 1'b0, 1'b0, "basic");
      do_op(8'hFF, 8'h01, 1'b1, 1'b0, "carry");
      do_op(8'h7F, 8'h01, 1'b0, 1'b0, "ovf");
      do_op(8'h80, 8'h80, 1'b0, 1'b0, "negovf");
`ifdef SEQ_ADDER_SUB_EN
      do_op(8'h10, 8'h20, 1'b0, 1'b1, "sub_borrow");
      do_op(8'h80, 8'h01, 1'b1, 1'b1, "sub_ovf");
`endif

      // start while busy must be ignored
      @(negedge clk);
      a = 8'h3C; b = 8'h05; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      pulses = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         start = (i == 2);
         if (i == 2) a = 8'h00;
         @(posedge clk);
         #1;
         if (done) begin
            pulses++;
            check("ignore:when", 32'(i), 32'(NCHUNK));
            check("ignore:s", 32'(s), 32'h41);
         end
      end
      check("ignore:pulses", 32'(pulses), 32'd1);

      // start held high: one op every NCHUNK+1 cycles
      model(8'h12, 8'h34, 1'b0, 1'b0, es, ec, eo);
      @(negedge clk);
      a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
      pulses = 0;
      last = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            pulses++;
            if (last < 0) check("hold:first", 32'(i), 32'(NCHUNK + 1));
            else          check("hold:gap", 32'(i - last), 32'(NCHUNK + 1));
            check("hold:s", 32'(s), 32'(es));
            last = i;
         end
      end
      start = 1'b0;
      check("hold:pulses", 32'(pulses), 32'd4);
      @(posedge clk);
      #1;
      check("hold:idle", 32'(done | busy), 32'd0);

      // asynchronous reset in the middle of an operation
      @(negedge clk);
      a = 8'h55; b = 8'h22; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort:busy", 32'(busy), 32'd0);
      check("abort:done", 32'(done), 32'd0);
      check("abort:s", 32'(s), 32'd0);
      check("abort:cout", 32'(cout), 32'd0);
      check("abort:ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      check("abort:no_done", 32'(pulses), 32'd0);
      do_op(8'h55, 8'h22, 1'b1, 1'b0, "after_abort");

      for (int n = 0; n < 30; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
`ifdef SEQ_ADDER_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         do_op(ra, rb, 1'($urandom), rs, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
